// File: rtl/ren_wb_pkg.sv
// Shared definitions for the Wishbone job master: FSM state encoding and
// fixed bus constants used by the master and its helpers.
package ren_wb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WFETCH = 3'd1,
    BUS    = 3'd2,
    RPUSH  = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Byte distance between consecutive 32-bit words.
  localparam logic [31:0] WORD_STRIDE = 32'd4;
  // Every beat is a full-word access.
  localparam logic [3:0]  SEL_ALL     = 4'hF;

endpackage

// File: rtl/ren_wb_timeout.sv
// Ack-timeout counter: counts cycles a beat waits for ack, flags expiry.
// Latency: expired is combinational from the current count and inc.
// Backpressure: none; clr has priority over inc.
module ren_wb_timeout #(
  parameter int TO_WIDTH = 8,
  parameter int TIMEOUT  = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TO_WIDTH-1:0] cnt;

  // Count stalled cycles; saturate so a stuck count never wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + TO_WIDTH'(1);
    end
  end

  // Fires on the stalled cycle whose increment brings the count to TIMEOUT,
  // so strobe is held for exactly TIMEOUT unanswered cycles.
  assign expired = inc && (cnt == TO_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/ren_wb_master.sv
// Wishbone classic initiator running N-word write/read jobs from/to streams.
// Latency: job accept to first strobe 1 cycle (read) or 1 cycle after stream data (write).
// Backpressure: write stream stalls hold bus idle; read stream stalls hold the next beat.
module ren_wb_master
  import ren_wb_pkg::*;
#(
  parameter int LEN_WIDTH = 7,
  parameter int TO_WIDTH  = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic                 job_we_i,
  input  logic [31:0]          job_base_i,
  input  logic [LEN_WIDTH-1:0] job_len_i,
  input  logic [31:0]          wr_data_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  output logic [31:0]          rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q;
  logic                 we_q;
  logic [31:0]          adr_q, dat_q, rd_dat_q;
  logic                 cyc_q, bus_we_q, done_q, busy_q, err_q;
  logic [3:0]           sel_q;
  logic                 job_acc, wr_take, rd_take, beat_ack, enter_bus;
  logic                 to_clr, to_inc, to_expired;

  // Stream handshakes are decoded straight from state.
  assign job_ready_o = (state_q == IDLE);
  assign wr_ready_o  = (state_q == WFETCH);
  assign rd_valid_o  = (state_q == RPUSH);

  assign job_acc   = job_valid_i && job_ready_o;
  assign wr_take   = wr_valid_i && wr_ready_o;
  assign rd_take   = rd_ready_i && rd_valid_o;
  // Ack only counts while a beat is actually on the bus.
  assign beat_ack  = (state_q == BUS) && wbm_ack_i;
  assign enter_bus = (state_d == BUS);

  // Timer runs only inside a beat; any other state clears it for the next one.
  assign to_clr = (state_q != BUS);
  assign to_inc = (state_q == BUS) && !wbm_ack_i;

  ren_wb_timeout #(
    .TO_WIDTH (TO_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .clr     (to_clr),
    .inc     (to_inc),
    .expired (to_expired)
  );

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode; ack wins over a timeout landing in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (job_acc) begin
          if (job_len_i == '0) state_d = DONE;
          else if (job_we_i)   state_d = WFETCH;
          else                 state_d = BUS;
        end
      end
      WFETCH: begin
        if (wr_take) state_d = BUS;
      end
      BUS: begin
        if (wbm_ack_i) begin
          if (!we_q)                          state_d = RPUSH;
          else if (rem_q == LEN_WIDTH'(1))    state_d = DONE;
          else                                state_d = WFETCH;
        end else if (to_expired) begin
          state_d = DONE;
        end
      end
      RPUSH: begin
        if (rd_take) state_d = (rem_q == '0) ? DONE : BUS;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered bus/status outputs and job datapath (address, count, data).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cyc_q    <= 1'b0;
      sel_q    <= 4'h0;
      bus_we_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      rem_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      rd_dat_q <= '0;
    end else begin
      // Strobe is set only on BUS entry, so it always drops for a cycle after an ack.
      cyc_q    <= enter_bus;
      sel_q    <= enter_bus ? SEL_ALL : 4'h0;
      bus_we_q <= enter_bus && (job_acc ? job_we_i : we_q);
      done_q   <= (state_d == DONE);
      busy_q   <= (state_d != IDLE);
      if (job_acc) begin
        adr_q <= job_base_i & ~32'h3;
        rem_q <= job_len_i;
        we_q  <= job_we_i;
        err_q <= 1'b0;
      end
      if (wr_take) dat_q <= wr_data_i;
      if (beat_ack) begin
        adr_q <= adr_q + WORD_STRIDE;
        rem_q <= rem_q - LEN_WIDTH'(1);
        if (!we_q) rd_dat_q <= wbm_dat_i;
      end else if (to_expired) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = bus_we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rd_data_o = rd_dat_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule
